// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   - FSM state encoding (3 bits, also exported on state_dbg)
//   - Default timing constants for the supervisor parameters
package pll_sup_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_LOST      = 3'd4
  } state_e;

  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 4096;
  localparam int DEF_LOST_DEBOUNCE = 4;
  localparam int DEF_CNT_W         = 16;

endpackage

// File: rtl/pll_lock_supervisor_sync_bit.sv
// sync_bit: SYNC_STAGES-deep flop chain that brings a single asynchronous
// status bit into the clk domain. All stages reset asynchronously to 0.
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset
//   d    in   asynchronous input bit
//   q    out  synchronised bit (last stage), SYNC_STAGES cycles of latency
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: qualifies the PLL locked flag on the board reference
// clock and holds sys_rst until lock has been stable for STABLE_CYCLES
// cycles. Debounced lock losses are counted (saturating) for readout.
// Optional build macro PLL_SUPERVISOR_IRQ_EN adds a sticky loss interrupt.
// Ports:
//   CLK         in   board reference clock (PLL input clock)
//   RST         in   asynchronous active-high reset
//   pll_locked  in   PLL locked output, asynchronous to CLK
//   soft_reset  in   single-cycle request to re-enter the reset hold
//   cnt_clear   in   single-cycle clear of loss_count
//   sys_rst     out  active-high reset for PLL-clocked logic
//   pll_ok      out  high while in RUN
//   loss_count  out  saturating lock-loss event count
//   state_dbg   out  current FSM state encoding
//   loss_irq    out  (PLL_SUPERVISOR_IRQ_EN) sticky lock-loss flag
//   irq_ack     in   (PLL_SUPERVISOR_IRQ_EN) clears loss_irq
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int LOST_DEBOUNCE = DEF_LOST_DEBOUNCE,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             pll_locked,
  input  logic             soft_reset,
  input  logic             cnt_clear,
  output logic             sys_rst,
  output logic             pll_ok,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state_dbg
`ifdef PLL_SUPERVISOR_IRQ_EN
  ,
  output logic             loss_irq,
  input  logic             irq_ack
`endif
);

  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
  localparam logic [7:0]  DEB_LAST    = 8'(LOST_DEBOUNCE - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic lk_s;

  sync_bit #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk (CLK),
    .rst (RST),
    .d   (pll_locked),
    .q   (lk_s)
  );

  state_e           state_q,      state_d;
  logic [15:0]      stable_cnt_q, stable_cnt_d;
  logic [7:0]       deb_cnt_q,    deb_cnt_d;
  logic [CNT_W-1:0] loss_count_q, loss_count_d;
  logic             sys_rst_q,    sys_rst_d;
  logic             pll_ok_q,     pll_ok_d;

  always_comb begin
    state_d      = state_q;
    stable_cnt_d = stable_cnt_q;
    deb_cnt_d    = deb_cnt_q;
    loss_count_d = loss_count_q;

    case (state_q)
      ST_HOLD: begin
        state_d      = ST_WAIT_LOCK;
        stable_cnt_d = '0;
        deb_cnt_d    = '0;
      end
      ST_WAIT_LOCK: begin
        if (lk_s) begin
          state_d      = ST_STABLE;
          stable_cnt_d = 16'd1;
        end
      end
      ST_STABLE: begin
        if (!lk_s) begin
          // Lock dropped before qualification: restart, not a loss event.
          state_d      = ST_WAIT_LOCK;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == STABLE_LAST) begin
          state_d      = ST_RUN;
          stable_cnt_d = '0;
          deb_cnt_d    = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (lk_s) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          // This is the LOST_DEBOUNCE-th consecutive low cycle.
          state_d   = ST_LOST;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + 8'd1;
        end
      end
      ST_LOST: begin
        state_d = ST_WAIT_LOCK;
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase

    // soft_reset overrides every transition, including a debounce expiry.
    if (soft_reset && (state_q != ST_HOLD)) begin
      state_d      = ST_HOLD;
      stable_cnt_d = '0;
      deb_cnt_d    = '0;
    end

    // Clear first so a coincident loss leaves the count at 1.
    if (cnt_clear) begin
      loss_count_d = '0;
    end
    if (state_q == ST_LOST) begin
      loss_count_d = sat_inc(loss_count_d);
    end

    // Outputs decoded from the next state so they are registered and
    // change in the first cycle of the new state.
    sys_rst_d = (state_d != ST_RUN);
    pll_ok_d  = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_HOLD;
      stable_cnt_q <= '0;
      deb_cnt_q    <= '0;
      loss_count_q <= '0;
      sys_rst_q    <= 1'b1;
      pll_ok_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      stable_cnt_q <= stable_cnt_d;
      deb_cnt_q    <= deb_cnt_d;
      loss_count_q <= loss_count_d;
      sys_rst_q    <= sys_rst_d;
      pll_ok_q     <= pll_ok_d;
    end
  end

  assign sys_rst    = sys_rst_q;
  assign pll_ok     = pll_ok_q;
  assign loss_count = loss_count_q;
  assign state_dbg  = state_q;

`ifdef PLL_SUPERVISOR_IRQ_EN
  logic loss_irq_q, loss_irq_d;

  // Set (cycle after LOST) takes priority over a simultaneous ack.
  always_comb begin
    loss_irq_d = loss_irq_q;
    if (irq_ack) begin
      loss_irq_d = 1'b0;
    end
    if (state_q == ST_LOST) begin
      loss_irq_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      loss_irq_q <= 1'b0;
    end else begin
      loss_irq_q <= loss_irq_d;
    end
  end

  assign loss_irq = loss_irq_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 16;
  localparam int LOST_DEBOUNCE = 4;
  localparam int CNT_W         = 4;

  logic             CLK = 1'b0;
  logic             RST;
  logic             pll_locked;
  logic             soft_reset;
  logic             cnt_clear;
  logic             sys_rst;
  logic             pll_ok;
  logic [CNT_W-1:0] loss_count;
  logic [2:0]       state_dbg;
  logic             loss_irq;
  logic             irq_ack;

  int checks = 0;
  int errors = 0;
  int exp_loss = 0;
  int n_loss = 0;

  always #5 CLK = ~CLK;

  pll_lock_supervisor #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .LOST_DEBOUNCE(LOST_DEBOUNCE),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .pll_locked (pll_locked),
    .soft_reset (soft_reset),
    .cnt_clear  (cnt_clear),
    .sys_rst    (sys_rst),
    .pll_ok     (pll_ok),
    .loss_count (loss_count),
    .state_dbg  (state_dbg)
`ifdef PLL_SUPERVISOR_IRQ_EN
    ,
    .loss_irq   (loss_irq),
    .irq_ack    (irq_ack)
`endif
  );

`ifndef PLL_SUPERVISOR_IRQ_EN
  assign loss_irq = 1'b0;
`endif

  typedef struct {
    int         low_len;
    logic [2:0] exp_state;
    logic       exp_sys_rst;
    int         exp_inc;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic wait_run(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sys_rst == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Drop lock from RUN until LOST, optionally clear/ack in the LOST cycle,
  // then relock back to RUN.
  task automatic force_loss(input bit clr, input bit ack);
    bit hit = 1'b0;
    pll_locked = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (state_dbg == 3'd4) begin
        hit = 1'b1;
        break;
      end
    end
    check("reach_lost", 32'(hit), 32'd1);
    check("lost_sys_rst", 32'(sys_rst), 32'd1);
    cnt_clear = clr;
    irq_ack   = ack;
    step();
    cnt_clear = 1'b0;
    irq_ack   = 1'b0;
    n_loss++;
    if (clr) exp_loss = 1;
    else if (exp_loss < 15) exp_loss++;
    pll_locked = 1'b1;
    wait_run("relock");
  endtask

  initial begin
    int  n;
    bit  saw_stable;
    bit  saw_wait;
    logic [2:0] st1;
    logic [CNT_W-1:0] saved;

    vecs[0] = '{1, 3'd3, 1'b0, 0};
    vecs[1] = '{2, 3'd3, 1'b0, 0};
    vecs[2] = '{3, 3'd3, 1'b0, 0};
    vecs[3] = '{4, 3'd1, 1'b1, 1};
    vecs[4] = '{5, 3'd1, 1'b1, 1};

    RST = 1'b1;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    cnt_clear  = 1'b0;
    irq_ack    = 1'b0;

    // Reset values
    step(); step();
    check("rst_sys_rst", 32'(sys_rst), 32'd1);
    check("rst_pll_ok", 32'(pll_ok), 32'd0);
    check("rst_loss_count", 32'(loss_count), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_irq", 32'(loss_irq), 32'd0);

    // Power-up lock: expect RUN 1 + SYNC_STAGES + (STABLE_CYCLES-1) edges after release
    pll_locked = 1'b1;
    step();
    RST = 1'b0;
    n = 0;
    st1 = 3'd7;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i == 1) st1 = state_dbg;
      if (sys_rst == 1'b0) begin
        n = i;
        break;
      end
    end
    check("pwr_first_state", 32'(st1), 32'd1);
    check("pwr_release_cycle", 32'(n), 32'd18);
    check("pwr_pll_ok", 32'(pll_ok), 32'd1);
    check("pwr_state_run", 32'(state_dbg), 32'd3);
    check("pwr_loss_count", 32'(loss_count), 32'd0);

    // Glitch table from RUN: 7-cycle observation window
    for (int v = 0; v < 5; v++) begin
      pll_locked = 1'b0;
      for (int c = 0; c < 7; c++) begin
        if (c == vecs[v].low_len) pll_locked = 1'b1;
        step();
      end
      pll_locked = 1'b1;
      exp_loss += vecs[v].exp_inc;
      n_loss   += vecs[v].exp_inc;
      check($sformatf("glitch%0d_state", vecs[v].low_len), 32'(state_dbg), 32'(vecs[v].exp_state));
      check($sformatf("glitch%0d_sys_rst", vecs[v].low_len), 32'(sys_rst), 32'(vecs[v].exp_sys_rst));
      check($sformatf("glitch%0d_pll_ok", vecs[v].low_len), 32'(pll_ok), 32'(!vecs[v].exp_sys_rst));
      check($sformatf("glitch%0d_loss", vecs[v].low_len), 32'(loss_count), 32'(exp_loss));
      if (vecs[v].exp_sys_rst) wait_run("glitch_relock");
    end

    // soft_reset in RUN
    saved = loss_count;
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    check("soft_state", 32'(state_dbg), 32'd0);
    check("soft_sys_rst", 32'(sys_rst), 32'd1);
    check("soft_pll_ok", 32'(pll_ok), 32'd0);
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (sys_rst == 1'b0) begin
        n = i;
        break;
      end
    end
    check("soft_relock_cycle", 32'(n), 32'd17);
    check("soft_loss_unchanged", 32'(loss_count), 32'(saved));

`ifdef PLL_SUPERVISOR_IRQ_EN
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("irq_ack_clear0", 32'(loss_irq), 32'd0);
    force_loss(1'b0, 1'b0);
    check("irq_set", 32'(loss_irq), 32'd1);
    for (int i = 0; i < 100; i++) step();
    check("irq_hold100", 32'(loss_irq), 32'd1);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    check("irq_ack_clear", 32'(loss_irq), 32'd0);
    force_loss(1'b0, 1'b1);
    check("irq_set_wins", 32'(loss_irq), 32'd1);
`endif

    // Saturation at 17 losses, then clear coincident with the 18th
    for (int k = 0; k < 30 && n_loss < 17; k++) force_loss(1'b0, 1'b0);
    check("sat_loss_events", 32'(n_loss), 32'd17);
    check("sat_loss_count", 32'(loss_count), 32'd15);
    force_loss(1'b1, 1'b0);
    check("clear_with_loss", 32'(loss_count), 32'd1);

    // Async RST mid-STABLE
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    step(); step(); step();
    check("pre_async_state", 32'(state_dbg), 32'd2);
    #2;
    RST = 1'b1;
    #1;
    check("async_state", 32'(state_dbg), 32'd0);
    check("async_sys_rst", 32'(sys_rst), 32'd1);
    check("async_pll_ok", 32'(pll_ok), 32'd0);
    check("async_loss_count", 32'(loss_count), 32'd0);

    // Unstable lock: one-cycle drop after 10 high cycles restarts qualification
    step(); step();
    RST = 1'b0;
    n = 0;
    saw_stable = 1'b0;
    saw_wait = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (i == 10) pll_locked = 1'b0;
      if (i == 11) pll_locked = 1'b1;
      if (state_dbg == 3'd2) saw_stable = 1'b1;
      if (saw_stable && state_dbg == 3'd1) saw_wait = 1'b1;
      if (sys_rst == 1'b0) begin
        n = i;
        break;
      end
    end
    check("unstable_back_to_wait", 32'(saw_wait), 32'd1);
    check("unstable_release_cycle", 32'(n), 32'd29);
    check("unstable_loss_count", 32'(loss_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
